serial_frame_rx: RTL

Serial frame receiver that consumes the registered 1-bit stream produced by the team's D flip-flop stage (`dff.q`) and turns it into bytes. It hunts for a sync byte, then assembles a fixed number of payload bytes MSB-first. It presents each byte on a valid/ready handshake with first/last-of-frame tags. It sits directly downstream of `dff` and upstream of any byte-wide consumer.

---
 rtl/serial_frame_rx_pkg.sv | 23 ++
 rtl/serial_frame_rx_if.sv | 36 +++
 rtl/serial_frame_rx_byte_hold_buf.sv | 45 ++++
 rtl/serial_frame_rx.sv | 119 +++++++++++
 4 files changed

// File: rtl/serial_frame_rx_pkg.sv
// ---------------------------------------------------------------------------
// serial_rx_pkg
// Shared types for the serial frame receiver.
//   BYTE_W      : payload byte width.
//   rx_state_t  : receiver FSM states (HUNT = searching for sync, RECV = payload).
//   rx_beat_t   : one entry of the output holding buffer {first, last, data}.
// ---------------------------------------------------------------------------
package serial_rx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic              first;
        logic              last;
        logic [BYTE_W-1:0] data;
    } rx_beat_t;

endpackage

// File: rtl/serial_frame_rx_if.sv
// ---------------------------------------------------------------------------
// serial_frame_rx_if
// Bundles the serial input and the byte-wide valid/ready output of the
// serial frame receiver.
//   data, bit_en          : serial bit and its sample enable (from dff.q)
//   byte_out, byte_valid  : payload byte and its valid flag
//   byte_ready            : consumer accept
//   first, last           : frame position tags, qualified by byte_valid
//   overrun               : one-cycle pulse when a completed byte is dropped
//   in_frame              : receiver is assembling payload
// Modports: slave = the receiver, master = the driver/consumer side.
// ---------------------------------------------------------------------------
interface serial_frame_rx_if;
    import serial_rx_pkg::*;

    logic              data;
    logic              bit_en;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              byte_ready;
    logic              first;
    logic              last;
    logic              overrun;
    logic              in_frame;

    modport slave (
        input  data, bit_en, byte_ready,
        output byte_out, byte_valid, first, last, overrun, in_frame
    );

    modport master (
        output data, bit_en, byte_ready,
        input  byte_out, byte_valid, first, last, overrun, in_frame
    );

endinterface

// File: rtl/serial_frame_rx_byte_hold_buf.sv
// ---------------------------------------------------------------------------
// byte_hold_buf
// One-entry valid/ready holding register for a tagged payload byte.
//   clk, reset : clock and synchronous active-low reset
//   load       : write din this cycle (caller only loads when accept=1)
//   din        : {first, last, byte} to store
//   ready      : downstream accepts the held entry
//   valid      : an entry is held
//   dout       : held entry, stable while valid && !ready
//   accept     : a load this cycle will be taken (empty or draining now)
// ---------------------------------------------------------------------------
module byte_hold_buf
    import serial_rx_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  rx_beat_t din,
    input  logic     ready,
    output logic     valid,
    output rx_beat_t dout,
    output logic     accept
);

    logic     valid_reg;
    rx_beat_t data_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            // A load on a draining cycle replaces the entry with no bubble.
            valid_reg <= 1'b1;
            data_reg  <= din;
        end else if (ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign accept = !valid_reg || ready;
    assign valid  = valid_reg;
    assign dout   = data_reg;

endmodule

// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
// Hunts for SYNC_PATTERN in a gated serial bit stream, then assembles
// FRAME_LEN payload bytes MSB-first and presents them on a valid/ready port
// with first/last tags. A byte completing while the holding buffer is still
// occupied is dropped, pulses overrun, and abandons the frame.
//   clk    : rising-edge clock
//   reset  : synchronous active-low reset
//   rx     : serial_frame_rx_if.slave (data, bit_en, byte_out, byte_valid,
//            byte_ready, first, last, overrun, in_frame)
// ---------------------------------------------------------------------------
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_PATTERN = 8'hA5,
    parameter int                FRAME_LEN    = 4      // 1..255
)
(
    input  logic              clk,
    input  logic              reset,
    serial_frame_rx_if.slave  rx
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    rx_state_t         state_reg;
    // Only the seven most recent bits are kept; the incoming bit completes
    // the byte, so the top bit of an 8-bit window would never be read.
    logic [BYTE_W-2:0] sr_reg;
    logic [3:0]        hunt_cnt_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        byte_cnt_reg;
    logic              overrun_reg;

    logic [BYTE_W-1:0] shifted;
    logic              sync_hit;
    logic              byte_done;
    logic              buf_accept;
    logic              buf_load;
    logic              byte_drop;
    logic              buf_valid;
    rx_beat_t          beat_in;
    rx_beat_t          beat_out;

    assign shifted   = {sr_reg, rx.data};

    // hunt_cnt >= 7 means seven fresh bits plus the current one: the window
    // never contains stale payload bits or the reset value of sr.
    assign sync_hit  = (state_reg == HUNT) && rx.bit_en &&
                       (shifted == SYNC_PATTERN) && (hunt_cnt_reg >= 4'd7);

    assign byte_done = (state_reg == RECV) && rx.bit_en && (bit_cnt_reg == 3'd7);
    assign buf_load  = byte_done && buf_accept;
    assign byte_drop = byte_done && !buf_accept;

    assign beat_in   = '{first: (byte_cnt_reg == 8'd0),
                         last:  (byte_cnt_reg == LAST_IDX),
                         data:  shifted};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= HUNT;
            sr_reg       <= '0;
            hunt_cnt_reg <= 4'd0;
            bit_cnt_reg  <= 3'd0;
            byte_cnt_reg <= 8'd0;
            overrun_reg  <= 1'b0;
        end else begin
            overrun_reg <= byte_drop;
            if (rx.bit_en) begin
                sr_reg <= shifted[BYTE_W-2:0];
                case (state_reg)
                    HUNT: begin
                        if (sync_hit) begin
                            state_reg    <= RECV;
                            hunt_cnt_reg <= 4'd0;
                            bit_cnt_reg  <= 3'd0;
                            byte_cnt_reg <= 8'd0;
                        end else if (hunt_cnt_reg != 4'd8) begin
                            hunt_cnt_reg <= hunt_cnt_reg + 4'd1;
                        end
                    end
                    RECV: begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (byte_done) begin
                            byte_cnt_reg <= byte_cnt_reg + 8'd1;
                            // Frame ends normally on its last byte, or is
                            // abandoned when the byte could not be stored.
                            if (byte_drop || (byte_cnt_reg == LAST_IDX)) begin
                                state_reg    <= HUNT;
                                hunt_cnt_reg <= 4'd0;
                            end
                        end
                    end
                    default: state_reg <= HUNT;
                endcase
            end
        end
    end

    byte_hold_buf u_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (buf_load),
        .din    (beat_in),
        .ready  (rx.byte_ready),
        .valid  (buf_valid),
        .dout   (beat_out),
        .accept (buf_accept)
    );

    assign rx.byte_out   = beat_out.data;
    assign rx.first      = beat_out.first;
    assign rx.last       = beat_out.last;
    assign rx.byte_valid = buf_valid;
    assign rx.overrun    = overrun_reg;
    assign rx.in_frame   = (state_reg == RECV);

endmodule
